// File: rtl/grid_move_engine.sv
// Applies one 2048 slide/merge move to the 4x4 grid through a single cell port,
// and runs a full-grid scan to detect the game-over condition.
module grid_move_engine #(
    parameter int SCORE_W = 16,
    parameter int WIN_EXP = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               op,
    input  logic [1:0]         dir,
    output logic               busy,
    output logic               done,
    output logic               moved,
    output logic               win,
    output logic               no_moves,
    output logic [SCORE_W-1:0] score_add,
    output logic [3:0]         cell_addr,
    input  logic [3:0]         cell_rdata,
    output logic               cell_we,
    output logic [3:0]         cell_wdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_MERGE = 3'd2,
        S_WRITE = 3'd3,
        S_SCAN  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t      state_r;
    logic [1:0]  dir_r;
    logic [1:0]  line_r;
    logic [1:0]  pos_r;
    logic [3:0]  line_buf_r [4];
    logic [3:0]  out_r      [4];
    logic [3:0]  prev_row_r [4];
    logic        possible_r;

    logic [3:0]  cmp_s [5];
    logic [3:0]  out_s [4];
    logic [2:0]  n_s;
    logic [1:0]  j_s;
    logic        skip_s;
    logic [31:0] merge_score_s;
    logic        merge_win_s;
    logic        merge_moved_s;
    logic        scan_hit_s;

    // Position k = 0 is always the edge the tiles slide toward.
    function automatic logic [3:0] map_addr(input logic [1:0] d, input logic [1:0] l,
                                            input logic [1:0] k);
        logic [3:0] a_v;
        case (d)
            2'd0:    a_v = {l, k};
            2'd1:    a_v = {l, 2'd3 - k};
            2'd2:    a_v = {k, l};
            2'd3:    a_v = {2'd3 - k, l};
            default: a_v = 4'd0;
        endcase
        return a_v;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [31:0] b);
        logic [32:0] sum_v;
        sum_v = 33'(a) + 33'(b);
        if (sum_v > 33'({SCORE_W{1'b1}})) begin
            return {SCORE_W{1'b1}};
        end else begin
            return sum_v[SCORE_W-1:0];
        end
    endfunction

    // Compact, pairwise-merge and refill one captured line.
    always_comb begin
        for (int i = 0; i < 5; i++) cmp_s[i] = 4'd0;
        for (int i = 0; i < 4; i++) out_s[i] = 4'd0;
        n_s           = 3'd0;
        j_s           = 2'd0;
        skip_s        = 1'b0;
        merge_score_s = 32'd0;
        merge_win_s   = 1'b0;
        merge_moved_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (line_buf_r[i] != 4'd0) begin
                cmp_s[n_s] = line_buf_r[i];
                n_s        = n_s + 3'd1;
            end else begin
                n_s = n_s;
            end
        end
        // Exponent 15 cannot grow further, so such tiles are left unmerged.
        for (int i = 0; i < 4; i++) begin
            if (skip_s) begin
                skip_s = 1'b0;
            end else if (cmp_s[i] == 4'd0) begin
                skip_s = 1'b0;
            end else if ((cmp_s[i] == cmp_s[i+1]) && (cmp_s[i] != 4'hF)) begin
                out_s[j_s]    = cmp_s[i] + 4'd1;
                merge_score_s = merge_score_s + (32'd1 << (cmp_s[i] + 4'd1));
                if ((5'(cmp_s[i]) + 5'd1) >= 5'(WIN_EXP)) begin
                    merge_win_s = 1'b1;
                end else begin
                    merge_win_s = merge_win_s;
                end
                skip_s = 1'b1;
                j_s    = j_s + 2'd1;
            end else begin
                out_s[j_s] = cmp_s[i];
                j_s        = j_s + 2'd1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (out_s[i] != line_buf_r[i]) begin
                merge_moved_s = 1'b1;
            end else begin
                merge_moved_s = merge_moved_s;
            end
        end
    end

    // Scan: in raster order prev_row_r[col-1] already holds the left neighbour.
    always_comb begin
        scan_hit_s = 1'b0;
        if (cell_rdata == 4'd0) begin
            scan_hit_s = 1'b1;
        end else if ((pos_r != 2'd0) && (cell_rdata == prev_row_r[pos_r - 2'd1])) begin
            scan_hit_s = 1'b1;
        end else if ((line_r != 2'd0) && (cell_rdata == prev_row_r[pos_r])) begin
            scan_hit_s = 1'b1;
        end else begin
            scan_hit_s = 1'b0;
        end
    end

    // Command sequencer with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= S_IDLE;
            dir_r      <= 2'd0;
            line_r     <= 2'd0;
            pos_r      <= 2'd0;
            possible_r <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                line_buf_r[i] <= 4'd0;
                out_r[i]      <= 4'd0;
                prev_row_r[i] <= 4'd0;
            end
            busy       <= 1'b0;
            done       <= 1'b0;
            moved      <= 1'b0;
            win        <= 1'b0;
            no_moves   <= 1'b0;
            score_add  <= {SCORE_W{1'b0}};
            cell_addr  <= 4'd0;
            cell_we    <= 1'b0;
            cell_wdata <= 4'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done    <= 1'b0;
                    cell_we <= 1'b0;
                    if (start) begin
                        busy      <= 1'b1;
                        line_r    <= 2'd0;
                        pos_r     <= 2'd0;
                        moved     <= 1'b0;
                        win       <= 1'b0;
                        no_moves  <= 1'b0;
                        score_add <= {SCORE_W{1'b0}};
                        if (!op) begin
                            dir_r     <= dir;
                            cell_addr <= map_addr(dir, 2'd0, 2'd0);
                            state_r   <= S_READ;
                        end else begin
                            cell_addr  <= 4'd0;
                            possible_r <= 1'b0;
                            state_r    <= S_SCAN;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_READ: begin
                    line_buf_r[pos_r] <= cell_rdata;
                    if (pos_r == 2'd3) begin
                        pos_r   <= 2'd0;
                        state_r <= S_MERGE;
                    end else begin
                        pos_r     <= pos_r + 2'd1;
                        cell_addr <= map_addr(dir_r, line_r, pos_r + 2'd1);
                    end
                end
                S_MERGE: begin
                    out_r      <= out_s;
                    moved      <= moved | merge_moved_s;
                    win        <= win | merge_win_s;
                    score_add  <= sat_add(score_add, merge_score_s);
                    cell_addr  <= map_addr(dir_r, line_r, 2'd0);
                    cell_wdata <= out_s[0];
                    cell_we    <= (out_s[0] != line_buf_r[0]);
                    pos_r      <= 2'd0;
                    state_r    <= S_WRITE;
                end
                S_WRITE: begin
                    if (pos_r == 2'd3) begin
                        cell_we <= 1'b0;
                        pos_r   <= 2'd0;
                        if (line_r == 2'd3) begin
                            done    <= 1'b1;
                            state_r <= S_DONE;
                        end else begin
                            line_r    <= line_r + 2'd1;
                            cell_addr <= map_addr(dir_r, line_r + 2'd1, 2'd0);
                            state_r   <= S_READ;
                        end
                    end else begin
                        pos_r      <= pos_r + 2'd1;
                        cell_addr  <= map_addr(dir_r, line_r, pos_r + 2'd1);
                        cell_wdata <= out_r[pos_r + 2'd1];
                        cell_we    <= (out_r[pos_r + 2'd1] != line_buf_r[pos_r + 2'd1]);
                    end
                end
                S_SCAN: begin
                    prev_row_r[pos_r] <= cell_rdata;
                    if ({line_r, pos_r} == 4'd15) begin
                        no_moves <= ~(possible_r | scan_hit_s);
                        done     <= 1'b1;
                        state_r  <= S_DONE;
                    end else begin
                        possible_r      <= possible_r | scan_hit_s;
                        {line_r, pos_r} <= {line_r, pos_r} + 4'd1;
                        cell_addr       <= {line_r, pos_r} + 4'd1;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    cell_we <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grid_move_engine.sv
// Directed bench for grid_move_engine: a behavioural grid memory on the cell port
// and a queue of expected command results checked at each completion.
module tb_grid_move_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [1:0]  dir = 2'd0;
    logic        busy, done, moved, win, no_moves;
    logic [15:0] score_add;
    logic [3:0]  cell_addr, cell_rdata, cell_wdata;
    logic        cell_we;

    logic [3:0]  grid    [16];
    logic [3:0]  ld_grid [16];
    logic        load_req = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic        moved;
        logic        win;
        logic        no_moves;
        logic [15:0] score;
        int          done_at;
        int          we_any;
    } exp_t;
    exp_t sb[$];

    grid_move_engine #(.SCORE_W(16), .WIN_EXP(11)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .dir(dir),
        .busy(busy), .done(done), .moved(moved), .win(win), .no_moves(no_moves),
        .score_add(score_add), .cell_addr(cell_addr), .cell_rdata(cell_rdata),
        .cell_we(cell_we), .cell_wdata(cell_wdata)
    );

    always #5 clk = ~clk;

    assign cell_rdata = grid[cell_addr];

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 16; i++) grid[i] <= ld_grid[i];
        end else if (cell_we) begin
            grid[cell_addr] <= cell_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_ld();
        for (int i = 0; i < 16; i++) ld_grid[i] = 4'd0;
    endtask

    task automatic apply_load();
        @(negedge clk);
        load_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0;
    endtask

    task automatic check4(input string tag, input int a0, input int a1, input int a2,
                          input int a3, input logic [15:0] exp);
        check(tag, {16'd0, grid[a0], grid[a1], grid[a2], grid[a3]}, {16'd0, exp});
    endtask

    task automatic expect_cmd(input string tag, input logic mv, input logic w, input logic nm,
                              input logic [15:0] sc, input int dat, input int we_any);
        exp_t e;
        e.tag = tag; e.moved = mv; e.win = w; e.no_moves = nm;
        e.score = sc; e.done_at = dat; e.we_any = we_any;
        sb.push_back(e);
    endtask

    // Issues one command; glitch > 0 re-pulses start in that busy cycle.
    task automatic run_cmd(input logic o, input logic [1:0] d, input int glitch);
        exp_t e;
        int done_cnt, done_at, we_cnt, busy_bad, limit;
        done_cnt = 0; done_at = -1; we_cnt = 0; busy_bad = 0;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        limit = e.done_at + 4;
        @(negedge clk);
        op = o; dir = d; start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= limit; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (cyc == glitch) start = 1'b1;
            if (cyc == glitch + 1) start = 1'b0;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
            end
            if (cell_we) we_cnt++;
            if (busy !== (cyc <= e.done_at)) busy_bad++;
        end
        check({e.tag, "_done_at"}, done_at, e.done_at);
        check({e.tag, "_done_cnt"}, done_cnt, 32'd1);
        check({e.tag, "_busy"}, busy_bad, 32'd0);
        check({e.tag, "_flags"}, {29'd0, moved, win, no_moves}, {29'd0, e.moved, e.win, e.no_moves});
        check({e.tag, "_score"}, {16'd0, score_add}, {16'd0, e.score});
        if (e.we_any == 0) check({e.tag, "_we_count"}, we_cnt, 32'd0);
    endtask

    initial begin
        clear_ld();
        for (int i = 0; i < 16; i++) grid[i] = 4'd0;
        repeat (3) @(posedge clk);
        #1 check("reset_outputs",
                 {2'd0, busy, done, moved, win, no_moves, score_add, cell_we, cell_addr, cell_wdata},
                 32'd0);
        @(negedge clk) rst = 1'b1;

        // Left, row0 = [1,1,2,2]
        clear_ld(); ld_grid[0] = 4'd1; ld_grid[1] = 4'd1; ld_grid[2] = 4'd2; ld_grid[3] = 4'd2;
        apply_load();
        expect_cmd("t1_left", 1'b1, 1'b0, 1'b0, 16'd12, 37, 1);
        run_cmd(1'b0, 2'd0, 0);
        check4("t1_row0", 0, 1, 2, 3, 16'h2300);

        // Left, row0 = [1,1,1,1]
        clear_ld(); for (int i = 0; i < 4; i++) ld_grid[i] = 4'd1;
        apply_load();
        expect_cmd("t2_left4", 1'b1, 1'b0, 1'b0, 16'd8, 37, 1);
        run_cmd(1'b0, 2'd0, 0);
        check4("t2_row0", 0, 1, 2, 3, 16'h2200);

        // Right, row1 = [0,1,1,1]
        clear_ld(); ld_grid[5] = 4'd1; ld_grid[6] = 4'd1; ld_grid[7] = 4'd1;
        apply_load();
        expect_cmd("t2_right", 1'b1, 1'b0, 1'b0, 16'd4, 37, 1);
        run_cmd(1'b0, 2'd1, 0);
        check4("t2_row1", 4, 5, 6, 7, 16'h0012);

        // Up on columns already packed with no equal neighbours
        clear_ld();
        for (int c = 0; c < 4; c++) begin
            ld_grid[c]     = 4'(c + 1);
            ld_grid[4 + c] = 4'(c + 2);
        end
        apply_load();
        expect_cmd("t3_up", 1'b0, 1'b0, 1'b0, 16'd0, 37, 0);
        run_cmd(1'b0, 2'd2, 0);
        check4("t3_col1", 1, 5, 9, 13, 16'h2300);

        // Down, column 2 = [0,0,10,10] -> 2048 tile
        clear_ld(); ld_grid[10] = 4'd10; ld_grid[14] = 4'd10;
        apply_load();
        expect_cmd("t4_down", 1'b1, 1'b1, 1'b0, 16'd2048, 37, 1);
        run_cmd(1'b0, 2'd3, 0);
        check4("t4_col2", 2, 6, 10, 14, 16'h000B);

        // Scan on a 1/2 checkerboard, then with a merge pair, then with a hole
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                ld_grid[r*4 + c] = ((r + c) % 2 == 1) ? 4'd2 : 4'd1;
        apply_load();
        expect_cmd("t5_full", 1'b0, 1'b0, 1'b1, 16'd0, 17, 0);
        run_cmd(1'b1, 2'd0, 0);
        ld_grid[5] = 4'd2;
        apply_load();
        expect_cmd("t5_pair", 1'b0, 1'b0, 1'b0, 16'd0, 17, 0);
        run_cmd(1'b1, 2'd0, 0);
        ld_grid[5] = 4'd1; ld_grid[15] = 4'd0;
        apply_load();
        expect_cmd("t5_hole", 1'b0, 1'b0, 1'b0, 16'd0, 17, 0);
        run_cmd(1'b1, 2'd0, 0);

        // Start pulse while busy is ignored
        clear_ld(); ld_grid[0] = 4'd1; ld_grid[1] = 4'd1; ld_grid[2] = 4'd2; ld_grid[3] = 4'd2;
        apply_load();
        expect_cmd("t6_glitch", 1'b1, 1'b0, 1'b0, 16'd12, 37, 1);
        run_cmd(1'b0, 2'd0, 10);
        check4("t6_row0", 0, 1, 2, 3, 16'h2300);

        // Reset in cycle 12 of a move aborts with all outputs cleared
        apply_load();
        @(negedge clk);
        op = 1'b0; dir = 2'd0; start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
        end
        check("t6_pre_reset_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1 check("t6_abort_outputs",
                 {2'd0, busy, done, moved, win, no_moves, score_add, cell_we, cell_addr, cell_wdata},
                 32'd0);
        @(negedge clk) rst = 1'b1;
        apply_load();
        expect_cmd("t6_after_rst", 1'b1, 1'b0, 1'b0, 16'd12, 37, 1);
        run_cmd(1'b0, 2'd0, 0);
        check4("t6_row0_after", 0, 1, 2, 3, 16'h2300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
